// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared constants and port-select encoding for dpram_port_arbiter
package dpram_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W = 16;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_sel_e;
endpackage

// File: rtl/dpram_port_arbiter_if.sv
// dpram_port_arbiter_if: requester-side valid/ready request bus and per-requester read response
//   master: req_valid/req_we/req_addr/req_wdata out; req_ready/rsp_valid/rsp_rdata in
//   slave:  mirror of master (arbiter side)
interface dpram_port_arbiter_if
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] rsp_rdata;
  modport master(output req_valid, req_we, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata);
  modport slave(input req_valid, req_we, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/dpram_port_arbiter_rr_pick.sv
// rr_pick: first set bit of req scanning start, start+1, ... mod N
//   req in N, start in IW; found out 1, idx out IW
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin : scan
    logic [IW-1:0] j;
    found = 1'b0;
    idx = start;
    j = '0;
    // descending offset so the nearest set bit is the last to assign
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(start) + k) % N);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/dual_port_ram.sv
// dual_port_ram: synchronous two-port RAM with registered read data
//   clk; we/addr/din/dout per port A and B
module dual_port_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end
endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of a dual-port RAM's two ports among NUM_REQ requesters
//   clk, rst_n (async active-low); bus: dpram_port_arbiter_if.slave request/response bus
//   we/addr/din_a/b out to RAM; dout_a/b in from RAM (registered); conflict_cnt out 16
//   DPRAM_ARB_STATS_EN enables the saturating conflict counter, else conflict_cnt = 0
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  dpram_port_arbiter_if.slave bus,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] din_a,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] din_b,
  input  logic [DATA_W-1:0] dout_a,
  input  logic [DATA_W-1:0] dout_b,
  output logic [CNT_W-1:0]  conflict_cnt
);
  localparam int IW = $clog2(NUM_REQ);
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, a_idx, b_idx, b_start;
  logic a_found, b_found, a_gnt, b_gnt, a_we, b_we, conflict;
  logic [ADDR_W-1:0] a_addr, b_addr, addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_W-1:0] a_din, b_din, din_a_q, din_a_d, din_b_q, din_b_d;
  logic [NUM_REQ-1:0] b_req, ready, rd_pend_q, rd_pend_d, port_sel_q, port_sel_d;
  assign b_start = nxt(a_idx);
  assign b_req = bus.req_valid & ~(NUM_REQ'(1) << a_idx);
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_a (.req(bus.req_valid), .start(rr_ptr_q), .found(a_found), .idx(a_idx));
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_b (.req(b_req), .start(b_start), .found(b_found), .idx(b_idx));
  always_comb begin
    a_addr = bus.req_addr[a_idx*ADDR_W +: ADDR_W];
    b_addr = bus.req_addr[b_idx*ADDR_W +: ADDR_W];
    a_din = bus.req_wdata[a_idx*DATA_W +: DATA_W];
    b_din = bus.req_wdata[b_idx*DATA_W +: DATA_W];
    a_we = bus.req_we[a_idx];
    b_we = bus.req_we[b_idx];
    // B loses a same-address clash involving a write; it is next in line via rr_ptr = A+1
    conflict = a_found & b_found & (a_addr == b_addr) & (a_we | b_we);
    a_gnt = rst_n & a_found;
    b_gnt = rst_n & b_found & ~conflict;
    ready = (a_gnt ? NUM_REQ'(1) << a_idx : '0) | (b_gnt ? NUM_REQ'(1) << b_idx : '0);
    rr_ptr_d = b_gnt ? nxt(b_idx) : a_gnt ? nxt(a_idx) : rr_ptr_q;
    rd_pend_d = ready & ~bus.req_we;
    port_sel_d = (port_sel_q & ~rd_pend_d) | (b_gnt ? rd_pend_d & (NUM_REQ'(1) << b_idx) : '0);
    addr_a_d = a_gnt ? a_addr : addr_a_q;
    din_a_d = a_gnt ? a_din : din_a_q;
    addr_b_d = b_gnt ? b_addr : addr_b_q;
    din_b_d = b_gnt ? b_din : din_b_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      rd_pend_q <= '0;
      port_sel_q <= '0;
      addr_a_q <= '0;
      din_a_q <= '0;
      addr_b_q <= '0;
      din_b_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_pend_q <= rd_pend_d;
      port_sel_q <= port_sel_d;
      addr_a_q <= addr_a_d;
      din_a_q <= din_a_d;
      addr_b_q <= addr_b_d;
      din_b_q <= din_b_d;
    end
  end
  assign we_a = a_gnt & a_we;
  assign we_b = b_gnt & b_we;
  assign addr_a = addr_a_d;
  assign din_a = din_a_d;
  assign addr_b = addr_b_d;
  assign din_b = din_b_d;
  assign bus.req_ready = ready;
  assign bus.rsp_valid = rd_pend_q;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign bus.rsp_rdata[i*DATA_W +: DATA_W] = (port_sel_e'(port_sel_q[i]) == PORT_B) ? dout_b : dout_a;
  end
`ifdef DPRAM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (conflict && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed self-checking bench for dpram_port_arbiter with a RAM behind it
module tb_dpram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic we_a, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] din_a, din_b, dout_a, dout_b;
  logic [15:0] conflict_cnt;
  int checks = 0;
  int errors = 0;
`ifdef DPRAM_ARB_STATS_EN
  localparam logic [15:0] EXP_CNT = 16'd1;
`else
  localparam logic [15:0] EXP_CNT = 16'd0;
`endif
  always #5 clk = ~clk;
  dpram_port_arbiter_if #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(8)) bus ();
  dpram_port_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_a(dout_a), .dout_b(dout_b), .conflict_cnt(conflict_cnt)
  );
  dual_port_ram #(.ADDR_W(4), .DATA_W(8)) u_ram (
    .clk(clk),
    .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b)
  );
  task automatic put(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
    bus.req_valid[i] = 1'b1;
    bus.req_we[i] = we;
    bus.req_addr[i*4 +: 4] = a;
    bus.req_wdata[i*8 +: 8] = d;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_we = '0;
    #2;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_we = 4'h3;
    bus.req_addr = 16'h3210;
    bus.req_wdata = 32'h44332211;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
    checks++; if ({we_a, we_b} !== 2'b00) begin errors++; $display("FAIL reset_we got %b exp 00", {we_a, we_b}); end
    tick();
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", bus.rsp_valid); end
    checks++; if (conflict_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0000", conflict_cnt); end
    apply_reset();
  endtask
  task automatic test_parallel_writes;
    apply_reset();
    put(0, 1'b1, 4'h0, 8'hEA);
    put(1, 1'b1, 4'h2, 8'h12);
    #1;
    checks++; if (bus.req_ready !== 4'b0011) begin errors++; $display("FAIL pw_ready got %b exp 0011", bus.req_ready); end
    checks++; if ({we_a, addr_a, din_a} !== {1'b1, 4'h0, 8'hEA}) begin errors++; $display("FAIL pw_port_a got %h exp 10ea", {we_a, addr_a, din_a}); end
    checks++; if ({we_b, addr_b, din_b} !== {1'b1, 4'h2, 8'h12}) begin errors++; $display("FAIL pw_port_b got %h exp 1212", {we_b, addr_b, din_b}); end
    tick();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL pw_no_rsp got %b exp 0000", bus.rsp_valid); end
    put(0, 1'b0, 4'h0, 8'h00);
    put(1, 1'b0, 4'h2, 8'h00);
    #1;
    checks++; if (bus.req_ready !== 4'b0011) begin errors++; $display("FAIL pr_ready got %b exp 0011", bus.req_ready); end
    checks++; if ({we_a, addr_a, we_b, addr_b} !== {1'b0, 4'h0, 1'b0, 4'h2}) begin errors++; $display("FAIL pr_ports got %h exp 02", {we_a, addr_a, we_b, addr_b}); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL pr_early_rsp got %b exp 0000", bus.rsp_valid); end
    tick();
    bus.req_valid = '0;
    checks++; if (bus.rsp_valid !== 4'b0011) begin errors++; $display("FAIL pr_rsp_valid got %b exp 0011", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata[15:0] !== 16'h12EA) begin errors++; $display("FAIL pr_rdata got %h exp 12ea", bus.rsp_rdata[15:0]); end
    tick();
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL pr_rsp_drop got %b exp 0000", bus.rsp_valid); end
  endtask
  task automatic test_conflict;
    apply_reset();
    put(0, 1'b1, 4'h4, 8'h32);
    put(1, 1'b0, 4'h4, 8'h00);
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL cf_ready got %b exp 0001", bus.req_ready); end
    checks++; if ({we_a, we_b} !== 2'b10) begin errors++; $display("FAIL cf_we got %b exp 10", {we_a, we_b}); end
    tick();
    bus.req_valid[0] = 1'b0;
    #1;
    checks++; if (conflict_cnt !== EXP_CNT) begin errors++; $display("FAIL cf_cnt got %h exp %h", conflict_cnt, EXP_CNT); end
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL cf_ready2 got %b exp 0010", bus.req_ready); end
    checks++; if ({we_a, addr_a} !== {1'b0, 4'h4}) begin errors++; $display("FAIL cf_port_a got %h exp 04", {we_a, addr_a}); end
    tick();
    bus.req_valid = '0;
    checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL cf_rsp_valid got %b exp 0010", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata[15:8] !== 8'h32) begin errors++; $display("FAIL cf_rdata got %h exp 32", bus.rsp_rdata[15:8]); end
    tick();
    checks++; if (conflict_cnt !== EXP_CNT) begin errors++; $display("FAIL cf_cnt_hold got %h exp %h", conflict_cnt, EXP_CNT); end
  endtask
  task automatic test_fairness;
    logic [3:0] exp_rdy [4];
    exp_rdy[0] = 4'b0011;
    exp_rdy[1] = 4'b1100;
    exp_rdy[2] = 4'b0011;
    exp_rdy[3] = 4'b1100;
    apply_reset();
    put(0, 1'b0, 4'h0, 8'h00);
    put(1, 1'b0, 4'h2, 8'h00);
    put(2, 1'b0, 4'h4, 8'h00);
    put(3, 1'b0, 4'h0, 8'h00);
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.req_ready !== exp_rdy[c]) begin errors++; $display("FAIL fair_ready c%0d got %b exp %b", c, bus.req_ready, exp_rdy[c]); end
      tick();
      if (c == 3) bus.req_valid = '0;
      checks++; if (bus.rsp_valid !== exp_rdy[c]) begin errors++; $display("FAIL fair_rsp c%0d got %b exp %b", c, bus.rsp_valid, exp_rdy[c]); end
      if (c[0] == 1'b0) begin
        checks++; if (bus.rsp_rdata[15:0] !== 16'h12EA) begin errors++; $display("FAIL fair_rdata01 c%0d got %h exp 12ea", c, bus.rsp_rdata[15:0]); end
      end else begin
        checks++; if (bus.rsp_rdata[31:16] !== 16'hEA32) begin errors++; $display("FAIL fair_rdata23 c%0d got %h exp ea32", c, bus.rsp_rdata[31:16]); end
      end
    end
    tick();
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL fair_idle got %b exp 0000", bus.rsp_valid); end
  endtask
  task automatic test_back_to_back;
    apply_reset();
    put(0, 1'b0, 4'h2, 8'h00);
    #1;
    checks++; if ({bus.req_ready, we_b} !== 5'b00010) begin errors++; $display("FAIL b2b_ready got %b exp 00010", {bus.req_ready, we_b}); end
    tick();
    checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata[7:0] !== 8'h12) begin errors++; $display("FAIL b2b_rsp1 got %b/%h exp 0001/12", bus.rsp_valid, bus.rsp_rdata[7:0]); end
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready2 got %b exp 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata[7:0] !== 8'h12) begin errors++; $display("FAIL b2b_rsp2 got %b/%h exp 0001/12", bus.rsp_valid, bus.rsp_rdata[7:0]); end
    tick();
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL b2b_end got %b exp 0000", bus.rsp_valid); end
  endtask
  task automatic test_mid_reset;
    apply_reset();
    put(2, 1'b0, 4'h7, 8'h00);
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL mr_ready got %b exp 0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL mr_rsp_in_reset got %b exp 0000", bus.rsp_valid); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL mr_rsp_after got %b exp 0000", bus.rsp_valid); end
    put(1, 1'b0, 4'h2, 8'h00);
    put(3, 1'b0, 4'h0, 8'h00);
    #1;
    checks++; if (bus.req_ready !== 4'b1010 || addr_a !== 4'h2 || addr_b !== 4'h0) begin errors++; $display("FAIL mr_rr_ptr got %b/%h/%h exp 1010/2/0", bus.req_ready, addr_a, addr_b); end
    tick();
    bus.req_valid = '0;
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    test_reset();
    test_parallel_writes();
    test_conflict();
    test_fairness();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
